mainfsm: RTL and testbench

Multicycle control state machine for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and mux selects. It produces the 2-bit `aluop` consumed by `aludec`, which turns `aluop` plus funct fields into `alucontrol`. Memory accesses wait on a ready handshake, so the same FSM works with single-cycle and wait-stated memories.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/mainfsm_outdec.sv | 79 +++++++
 rtl/mainfsm.sv | 93 +++++++++
 tb/tb_mainfsm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
// The ERROR state only exists when MAINFSM_ILLEGAL_TRAP_EN is defined.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    , ERROR
`endif
  } statetype;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
  localparam logic [1:0] RESULT_DATA      = 2'b01;
  localparam logic [1:0] RESULT_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mainfsm_outdec.sv
// Combinational map from FSM state (plus memready in FETCH) to datapath controls.
module mainfsm_outdec
  import riscv_pkg::*;
(
  input  statetype   state,
  input  logic       memready,
  output logic       branch,
  output logic       pcupdate,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       adrsrc,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop
);

  always_comb begin
    branch    = 1'b0;
    pcupdate  = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    adrsrc    = 1'b0;
    resultsrc = RESULT_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RD2;
    aluop     = ALUOP_ADD;
    case (state)
      // the fetch only commits (ir load, pc+4) once memory returns the word
      FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RESULT_ALURESULT;
        irwrite   = memready;
        pcupdate  = memready;
      end
      DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
      end
      MEMREAD: adrsrc = 1'b1;
      MEMWB: begin
        resultsrc = RESULT_DATA;
        regwrite  = 1'b1;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTER: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: regwrite = 1'b1;
      BEQ: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM: state register, next-state logic and illegal trap.
// Define MAINFSM_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky ERROR state.
module mainfsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       memready,
  output logic       branch,
  output logic       pcupdate,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       adrsrc,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illegal
);

  statetype state;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
  logic illegalq;
`endif

  // illegal gets its own flop so it never glitches through state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      illegalq <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH:    if (memready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTER;
            OP_IALU:      state <= EXECUTEI;
            OP_JAL:       state <= JAL;
            OP_BEQ:       state <= BEQ;
            default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
              state    <= ERROR;
              illegalq <= 1'b1;
`else
              state <= FETCH;
`endif
            end
          endcase
        end
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (memready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (memready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        ERROR:    state <= ERROR;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

`ifdef MAINFSM_ILLEGAL_TRAP_EN
  assign illegal = illegalq;
`else
  assign illegal = 1'b0;
`endif

  mainfsm_outdec u_outdec (
    .state     (state),
    .memready  (memready),
    .branch    (branch),
    .pcupdate  (pcupdate),
    .regwrite  (regwrite),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .adrsrc    (adrsrc),
    .resultsrc (resultsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop)
  );

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed vector table, multi-cycle corner sequences,
// and random instruction streams against a per-instruction step-list model.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic       memready = 1'b1;
  logic       branch, pcupdate, regwrite, memwrite, irwrite, adrsrc, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mainfsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .memready  (memready),
    .branch    (branch),
    .pcupdate  (pcupdate),
    .regwrite  (regwrite),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .adrsrc    (adrsrc),
    .resultsrc (resultsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .illegal   (illegal)
  );

  // output bundle: {branch,pcupdate,regwrite,memwrite,irwrite,adrsrc,resultsrc,alusrca,alusrcb,aluop,illegal}
  logic [14:0] actv;
  assign actv = {branch, pcupdate, regwrite, memwrite, irwrite, adrsrc,
                 resultsrc, alusrca, alusrcb, aluop, illegal};

  function automatic logic [14:0] mk(input logic br, input logic pc, input logic rw,
                                     input logic mw, input logic ir, input logic ad,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] ao,
                                     input logic il);
    return {br, pc, rw, mw, ir, ad, rs, sa, sb, ao, il};
  endfunction

  typedef enum int {S_F, S_D, S_ADR, S_RD, S_RWB, S_WR, S_XR, S_XI, S_AWB, S_BR, S_J, S_ERR} step_t;

  function automatic logic [14:0] expout(input step_t s, input logic mr);
    case (s)
      S_F:    return mk(0, mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
      S_D:    return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
      S_ADR:  return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
      S_RD:   return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      S_RWB:  return mk(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0);
      S_WR:   return mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      S_XR:   return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
      S_XI:   return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
      S_AWB:  return mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      S_BR:   return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
      S_J:    return mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
      default: return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    endcase
  endfunction

  // an instruction is the list of steps the spec assigns to its opcode
  function automatic void buildplan(input logic [6:0] o, ref step_t plan[$]);
    plan.delete();
    plan.push_back(S_F);
    plan.push_back(S_D);
    case (o)
      7'b0000011: begin plan.push_back(S_ADR); plan.push_back(S_RD); plan.push_back(S_RWB); end
      7'b0100011: begin plan.push_back(S_ADR); plan.push_back(S_WR); end
      7'b0110011: begin plan.push_back(S_XR); plan.push_back(S_AWB); end
      7'b0010011: begin plan.push_back(S_XI); plan.push_back(S_AWB); end
      7'b1100011: plan.push_back(S_BR);
      7'b1101111: begin plan.push_back(S_J); plan.push_back(S_AWB); end
      default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        plan.push_back(S_ERR);
`endif
      end
    endcase
  endfunction

  task automatic compareNow(input string name, input logic [14:0] exp);
    checks++;
    if (actv !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actv, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic m);
    op = o;
    memready = m;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] exp);
    @(negedge clk);
    compareNow(name, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    memready = 1'b1;
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    int          cyc;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];
  step_t plan[$];

  initial begin
    vecs.push_back('{"rst_fetch_mr1", 7'b0000011, 1, 1'b1, mk(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,0)});
    vecs.push_back('{"rst_fetch_mr0", 7'b0000011, 1, 1'b0, mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0)});
    vecs.push_back('{"lw_decode",     7'b0000011, 2, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0)});
    vecs.push_back('{"lw_memadr",     7'b0000011, 3, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0)});
    vecs.push_back('{"lw_memread",    7'b0000011, 4, 1'b1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0)});
    vecs.push_back('{"lw_memwb",      7'b0000011, 5, 1'b1, mk(0,0,1,0,0,0,2'b01,2'b00,2'b00,2'b00,0)});
    vecs.push_back('{"lw_refetch",    7'b0000011, 6, 1'b1, mk(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,0)});
    vecs.push_back('{"sw_memwrite",   7'b0100011, 4, 1'b1, mk(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0)});
    vecs.push_back('{"sw_refetch",    7'b0100011, 5, 1'b0, mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0)});
    vecs.push_back('{"r_execute",     7'b0110011, 3, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0)});
    vecs.push_back('{"r_aluwb",       7'b0110011, 4, 1'b0, mk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0)});
    vecs.push_back('{"i_execute",     7'b0010011, 3, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0)});
    vecs.push_back('{"beq_cycle",     7'b1100011, 3, 1'b1, mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0)});
    vecs.push_back('{"beq_refetch",   7'b1100011, 4, 1'b1, mk(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,0)});
    vecs.push_back('{"jal_cycle",     7'b1101111, 3, 1'b1, mk(0,1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0)});
    vecs.push_back('{"jal_aluwb",     7'b1101111, 4, 1'b1, mk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0)});
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    vecs.push_back('{"bad_op_trap",   7'b1111111, 3, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1)});
`else
    vecs.push_back('{"bad_op_nop",    7'b1111111, 3, 1'b1, mk(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,0)});
`endif

    foreach (vecs[i]) begin
      doReset();
      for (int c = 1; c < vecs[i].cyc; c++) begin
        applyStimulus(vecs[i].op, 1'b1);
        nextCycle();
      end
      applyStimulus(vecs[i].op, vecs[i].mr);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // sw stalled three cycles in MEMWRITE: memwrite must hold for four cycles
    begin
      logic  mrs[8]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      step_t steps[8] = '{S_F, S_D, S_ADR, S_WR, S_WR, S_WR, S_WR, S_F};
      doReset();
      for (int c = 0; c < 8; c++) begin
        applyStimulus(7'b0100011, mrs[c]);
        checkOutput($sformatf("sw_stall_c%0d", c + 1), expout(steps[c], mrs[c]));
        nextCycle();
      end
    end

    // reset asserted mid-store must drop memwrite without waiting for a clock
    doReset();
    for (int c = 1; c < 4; c++) begin
      applyStimulus(7'b0100011, 1'b1);
      nextCycle();
    end
    applyStimulus(7'b0100011, 1'b0);
    #1;
    compareNow("sw_before_reset", expout(S_WR, 1'b0));
    reset_n = 1'b0;
    #1;
    compareNow("sw_async_reset", expout(S_F, 1'b0));
    #1;
    reset_n = 1'b1;

`ifdef MAINFSM_ILLEGAL_TRAP_EN
    doReset();
    applyStimulus(7'b1111111, 1'b1);
    nextCycle();
    nextCycle();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(7'b1111111, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("error_hold_%0d", c), expout(S_ERR, memready));
      nextCycle();
    end
    memready = 1'b1;
    reset_n = 1'b0;
    #1;
    compareNow("error_cleared", expout(S_F, 1'b1));
    #1;
    reset_n = 1'b1;
`endif

    // random instruction stream against the step-list model
    begin
      logic [6:0] legal[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                               7'b0010011, 7'b1100011, 7'b1101111};
      logic [6:0] curop = 7'b0;
      int errsteps = 0;
      logic mr;
      doReset();
      plan.delete();
      for (int n = 0; n < 600; n++) begin
        if (plan.size() == 0) begin
          if ($urandom_range(0, 9) < 8) curop = legal[$urandom_range(0, 5)];
          else curop = 7'($urandom_range(0, 127));
          buildplan(curop, plan);
        end
        mr = ($urandom_range(0, 3) != 0);
        applyStimulus(curop, mr);
        checkOutput($sformatf("rand_%0d_op%b", n, curop), expout(plan[0], mr));
        if (plan[0] == S_ERR) begin
          errsteps++;
          if (errsteps >= 3) begin
            errsteps = 0;
            plan.delete();
            doReset();
            continue;
          end
        end else if (!((plan[0] == S_F || plan[0] == S_RD || plan[0] == S_WR) && !mr)) begin
          void'(plan.pop_front());
        end
        nextCycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
